// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared widths and state encoding for the Montgomery blocks
package multiplier_pkg;
  localparam int DATA_LENGTH = 64;
  localparam int MTD_CNT_W = $clog2(DATA_LENGTH) + 1;
  typedef enum logic [1:0] {MTD_IDLE, MTD_RUN, MTD_DONE} mtd_state_e;
endpackage

// File: rtl/mod_double_sub.sv
// mod_double_sub: one modular doubling step, t -> (2t >= q ? 2t - q : 2t)
module mod_double_sub #(
  parameter int W = 65
) (
  input  logic [W-1:0] t_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] t_o
);
  logic [W-1:0] t2;
  always_comb begin
    t2  = {t_i[W-2:0], 1'b0};
    t_o = (t2 >= q_i) ? t2 - q_i : t2;
  end
endmodule

// File: rtl/montgomery_to_domain.sv
// montgomery_to_domain: iterative x*2^q_bl mod q, one modular doubling per cycle
// Optional MONT_TO_DOMAIN_CHECK_EN adds err_o flagging illegal operands at accept.
module montgomery_to_domain #(
  parameter int DATA_LENGTH = multiplier_pkg::DATA_LENGTH,
  parameter int CNT_W = $clog2(DATA_LENGTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] q_i,
  input  logic [DATA_LENGTH-1:0] q_bl_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
`ifdef MONT_TO_DOMAIN_CHECK_EN
  output logic                   busy_o,
  output logic                   err_o
`else
  output logic                   busy_o
`endif
);
  import multiplier_pkg::*;
  mtd_state_e state_q, state_d;
  logic [DATA_LENGTH:0] t_q, t_d, step;
  logic [DATA_LENGTH-1:0] q_q, q_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, qbl_lo;
  mod_double_sub #(.W(DATA_LENGTH + 1)) u_step (
    .t_i(t_q),
    .q_i({1'b0, q_q}),
    .t_o(step)
  );
  assign qbl_lo = q_bl_i[CNT_W-1:0];
`ifdef MONT_TO_DOMAIN_CHECK_EN
  logic err_q, err_d, bad_in;
  assign bad_in = !q_i[0] || q_i == '0 || x_i >= q_i ||
                  q_bl_i >= DATA_LENGTH || (q_i >> q_bl_i) != '0;
  assign err_o = err_q;
`else
  logic unused_qbl;
  assign unused_qbl = ^q_bl_i[DATA_LENGTH-1:CNT_W];
`endif
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef MONT_TO_DOMAIN_CHECK_EN
    err_d    = err_q;
`endif
    if (state_q == MTD_RUN) begin
      t_d   = step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d  = MTD_DONE;
        result_d = step[DATA_LENGTH-1:0];
      end
    end else if (start_i) begin
      t_d     = {1'b0, x_i};
      q_d     = q_i;
      cnt_d   = qbl_lo;
      state_d = (qbl_lo == '0) ? MTD_DONE : MTD_RUN;
      result_d = (qbl_lo == '0) ? x_i : result_q;
`ifdef MONT_TO_DOMAIN_CHECK_EN
      err_d   = bad_in;
`endif
    end else begin
      state_d = MTD_IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MTD_IDLE;
      t_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef MONT_TO_DOMAIN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef MONT_TO_DOMAIN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end
  assign result_o = result_q;
  assign valid_o  = state_q == MTD_DONE;
  assign busy_o   = state_q == MTD_RUN;
endmodule

// File: tb/tb_montgomery_to_domain.sv
// tb_montgomery_to_domain: scoreboard bench against an arithmetic x*2^q_bl mod q model
module tb_montgomery_to_domain;
  logic clk = 0, rst = 1, start = 0;
  logic [63:0] x = '0, q = '0, qbl = '0;
  logic [63:0] result;
  logic valid, busy, err;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [63:0] res; logic err; int cyc; bit chk_res;} exp_t;
  exp_t sb[$];

  montgomery_to_domain dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .x_i(x), .q_i(q), .q_bl_i(qbl),
    .result_o(result), .valid_o(valid),
`ifdef MONT_TO_DOMAIN_CHECK_EN
    .busy_o(busy), .err_o(err)
`else
    .busy_o(busy)
`endif
  );
`ifndef MONT_TO_DOMAIN_CHECK_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mont(input logic [63:0] xv, qv, input int n);
    logic [127:0] p;
    p = (128'd1 << n) % {64'd0, qv};
    return 64'(({64'd0, xv} * p) % {64'd0, qv});
  endfunction

  function automatic logic ref_err(input logic [63:0] xv, qv, input int n);
    return !qv[0] || qv == 0 || xv >= qv || n >= 64 || {64'd0, qv} >= (128'd1 << n);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %0d expected no valid", result);
      end else begin
        e = sb.pop_front();
        if (e.chk_res) chk("result", result, e.res);
        chk("latency", 64'(cyc), 64'(e.cyc));
`ifdef MONT_TO_DOMAIN_CHECK_EN
        chk("err", {63'd0, err}, {63'd0, e.err});
`endif
      end
    end
  end

  // Called at a negedge; returns at the following negedge with start dropped.
  task automatic issue(input logic [63:0] xv, qv, input int n, input bit cr = 1);
    int w = 0;
    exp_t e;
    while (busy === 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy after %0d cycles expected idle", w);
    end
    start = 1;
    x = xv;
    q = qv;
    qbl = 64'(n);
    e.res = cr ? ref_mont(xv, qv, n) : '0;
    e.err = ref_err(xv, qv, n);
    e.cyc = cyc + n + 1;
    e.chk_res = cr;
    sb.push_back(e);
    @(negedge clk);
    start = 0;
    x = $urandom;
    q = $urandom;
    qbl = $urandom;
  endtask

  initial begin
    logic [63:0] rq, rx;
    int n, w;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_valid", {63'd0, valid}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    rst = 0;
    @(negedge clk);
    issue(3, 17, 5);
    for (int i = 0; i < 5; i++) begin
      chk("busy_run", {63'd0, busy}, 1);
      @(negedge clk);
    end
    chk("busy_done", {63'd0, busy}, 0);
    issue(1, 3329, 12);
    issue(3328, 3329, 12);
    issue(2, 64'h1FFF_FFFF_FFFF_FFFF, 61);
    issue(0, 64'h1FFF_FFFF_FFFF_FFFF, 61);
    issue(5, 17, 5);
    repeat (2) @(negedge clk);
    start = 1;
    x = 1;
    @(negedge clk);
    start = 0;
    issue(1, 3329, 12);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_result", result, 0);
    chk("midrst_valid", {63'd0, valid}, 0);
    chk("midrst_busy", {63'd0, busy}, 0);
    sb.delete(sb.size() - 1);
    rst = 0;
    @(negedge clk);
    issue(5, 7, 0);
    issue(4, 7, 0);
    issue(2, 64'h1FFF_FFFF_FFFF_FFFF, 61);
`ifdef MONT_TO_DOMAIN_CHECK_EN
    issue(3, 16, 5, 0);
    issue(20, 17, 5, 0);
`endif
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(1, 63);
      rq = ({$urandom, $urandom} & ((64'd1 << n) - 1)) | 64'd1;
      rx = (rq > 1) ? {$urandom, $urandom} % rq : 64'd0;
      if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 3) + (n > 4 ? n - 4 : 0);
      if (rq >= (64'd1 << n)) n = 64 - $countones({1'b0, ~rq[62:0]}) + 0;
      n = 0;
      for (int b = 0; b < 64; b++) if (rq[b]) n = b + 1;
      n = n + $urandom_range(0, (n < 60) ? 3 : 0);
      issue(rx, rq, n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
